lcd_id_timing: RTL and testbench
================================

Name: lcd_id_timing

Overview:
Front-end timing stage of the RGB LCD path, sitting between the panel pins and the character/pattern renderer.
- After reset it reads the panel strap ID from the RGB bus while the bus is tri-stated.
- It decodes the ID into one of five timing sets and then generates HS/VS/DE.
- It requests pixels from the renderer one cycle ahead of DE.
- The top level owns the inout pad, the pixel-clock divider and the lcd_clk output.

Parameters:
SETTLE_CYCLES, 16, cycles the bus stays tri-stated after reset before the ID is sampled (≥2).
DEFAULT_ID, 16'h4342, panel ID used when the strap code is unrecognised.

Ports:
sys_clk  in  1  pixel clock, as supplied by the top-level divider
sys_rst_n  in  1  asynchronous active-low reset
lcd_rgb_in  in  16  pad input (RGB565), read only during the ID phase
pixel_data  in  16  renderer pixel, valid one cycle after data_req
lcd_rgb_out  out  16  pad output data
lcd_rgb_oe  out  1  pad output enable; 1 = drive
lcd_de  out  1  data enable
lcd_hs  out  1  horizontal sync, active low
lcd_vs  out  1  vertical sync, active low
lcd_bl  out  1  backlight enable
data_req  out  1  pixel request to the renderer
pixel_xpos  out  11  x coordinate of the requested pixel
pixel_ypos  out  11  y coordinate of the requested pixel
h_disp  out  11  active width of the selected panel
v_disp  out  11  active height of the selected panel
lcd_id  out  16  decoded panel ID
id_unknown  out  1  strap code not in the table

Behaviour:
Clock and reset:
- Single clock domain (sys_clk). Reset is asynchronous, active-low (sys_rst_n).

Reset values:
- lcd_rgb_oe=0, lcd_rgb_out=0, lcd_de=0, lcd_hs=1, lcd_vs=1, lcd_bl=0, data_req=0.
- pixel_xpos=0, pixel_ypos=0, h_disp=0, v_disp=0, lcd_id=0, id_unknown=0.

FSM: SETTLE -> SAMPLE -> RUN.
- SETTLE: a counter runs 0..SETTLE_CYCLES-1 with oe=0. At terminal count, go to SAMPLE.
- SAMPLE (one cycle):
  - Register M = {lcd_rgb_in[4], lcd_rgb_in[10], lcd_rgb_in[15]}.
  - Decode M: 000 -> 4342, 001 -> 7084, 010 -> 7016, 100 -> 4384, 101 -> 1018.
  - Any other M -> DEFAULT_ID and id_unknown=1 (sticky until reset).
  - lcd_id, h_disp and v_disp are valid from the next cycle and then constant. Go to RUN.
- RUN:
  - oe=1 and lcd_bl=1 from the first RUN cycle.
  - The FSM never leaves RUN except on reset.

Timing table (sync, back porch, display, front porch, total):
- 4342: H 41,2,480,2,525; V 10,2,272,2,286.
- 7084: H 128,88,800,40,1056; V 2,33,480,10,525.
- 7016: H 20,140,1024,160,1344; V 3,20,600,12,635.
- 4384: H 128,88,800,40,1056; V 2,33,480,10,525.
- 1018: H 10,80,1280,70,1440; V 3,10,800,10,823.

Counters:
- h_cnt and v_cnt are 11-bit and start at 0 on RUN entry.
- h_cnt wraps at H_TOTAL-1.
- v_cnt increments only on h wrap and wraps at V_TOTAL-1; both wrap together at frame end.

Outputs in RUN (registered, one cycle after the counters):
- lcd_hs=0 while h_cnt<H_SYNC. lcd_vs=0 while v_cnt<V_SYNC.
- lcd_de=1 while h_cnt is in [HS+HB, HS+HB+HD) and v_cnt is in [VS+VB, VS+VB+VD).
- data_req is lcd_de advanced by exactly one cycle.
- pixel_xpos = h_cnt-(HS+HB)+1 while data_req=1, else 0. pixel_ypos = v_cnt-(VS+VB) while data_req=1, else 0.
- lcd_rgb_out = pixel_data while lcd_de=1, else 0.

Arithmetic:
- All timing constants are unsigned 11-bit; no overflow, since the maximum total is 1440.

Boundary cases:
- Last pixel of a line: data_req falls one cycle before lcd_de falls.
- Frame wrap: vs asserts on the cycle after v_cnt wraps to 0.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously), oe=0 (bus released), and the ID is re-read after reset.

Decomposition:
- Package lcd_pkg holds:
  - the ID constants and the strap-code localparams;
  - a timing record type {hs, hb, hd, hf, ht, vs, vb, vd, vf, vt};
  - a function id_to_timing(M) returning the record plus the unknown flag.
- One natural sub-module, lcd_sync_gen: counters plus HS/VS/DE/data_req/xpos/ypos generation, taking the timing record as a static input.
- The top of lcd_id_timing holds the FSM, the ID latch and the output mux.

Test Plan:
- lcd_rgb_in=16'h0010, release reset -> oe=0 for SETTLE_CYCLES+1 cycles; lcd_id=16'h4384; h_disp=800; v_disp=480; id_unknown=0; bl=1.
- lcd_rgb_in=16'h0000 -> lcd_id=16'h4342; hs low pulse 41 cycles, period 525; DE high 480 cycles per line on 272 lines; vs period 525*286 cycles.
- lcd_rgb_in=16'h8410 (M=111) -> id_unknown=1; lcd_id=16'h4342 timing.
- 7016 panel (M=010, lcd_rgb_in=16'h0400), renderer returns pixel_data=x^y -> first data_req at h_cnt=159 with xpos=1, ypos=0; lcd_rgb_out equals the value for the previous cycle's request; last request of a line has xpos=1024.
- Assert sys_rst_n=0 mid-line while DE=1 -> de, bl, oe, data_req drop to 0 and hs, vs go to 1 within the same cycle. Change lcd_rgb_in to 16'h8000 (M=001), release reset -> lcd_id=16'h7084.
- Over three frames check: hs count = 3*V_TOTAL, DE cycles = 3*HD*VD, no DE during hs or vs low.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, panel ID constants and strap decoding for the RGB LCD timing path.
package lcd_pkg;

  // Panel IDs as reported on lcd_id
  localparam logic [15:0] ID_4342 = 16'h4342;
  localparam logic [15:0] ID_7084 = 16'h7084;
  localparam logic [15:0] ID_7016 = 16'h7016;
  localparam logic [15:0] ID_4384 = 16'h4384;
  localparam logic [15:0] ID_1018 = 16'h1018;

  // Strap codes M = {rgb[4], rgb[10], rgb[15]}
  localparam logic [2:0] M_4342 = 3'b000;
  localparam logic [2:0] M_7084 = 3'b001;
  localparam logic [2:0] M_7016 = 3'b010;
  localparam logic [2:0] M_4384 = 3'b100;
  localparam logic [2:0] M_1018 = 3'b101;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_RUN    = 2'd2
  } lcd_state_t;

  // Sync, back porch, display, front porch, total -- horizontal then vertical
  typedef struct packed {
    logic [10:0] hs;
    logic [10:0] hb;
    logic [10:0] hd;
    logic [10:0] hf;
    logic [10:0] ht;
    logic [10:0] vs;
    logic [10:0] vb;
    logic [10:0] vd;
    logic [10:0] vf;
    logic [10:0] vt;
  } lcd_timing_t;

  typedef struct packed {
    lcd_timing_t tim;
    logic [15:0] id;
    logic        unknown;
  } lcd_decode_t;

  localparam lcd_timing_t T_480X272 = '{11'd41, 11'd2, 11'd480, 11'd2, 11'd525,
                                        11'd10, 11'd2, 11'd272, 11'd2, 11'd286};
  localparam lcd_timing_t T_800X480 = '{11'd128, 11'd88, 11'd800, 11'd40, 11'd1056,
                                        11'd2, 11'd33, 11'd480, 11'd10, 11'd525};
  localparam lcd_timing_t T_1024X600 = '{11'd20, 11'd140, 11'd1024, 11'd160, 11'd1344,
                                         11'd3, 11'd20, 11'd600, 11'd12, 11'd635};
  localparam lcd_timing_t T_1280X800 = '{11'd10, 11'd80, 11'd1280, 11'd70, 11'd1440,
                                         11'd3, 11'd10, 11'd800, 11'd10, 11'd823};

  // Timing set belonging to a panel ID; anything unlisted gets the 480x272 set
  function automatic lcd_timing_t timing_for_id(input logic [15:0] id);
    case (id)
      ID_7084, ID_4384: return T_800X480;
      ID_7016:          return T_1024X600;
      ID_1018:          return T_1280X800;
      default:          return T_480X272;
    endcase
  endfunction

  // Strap code to panel ID, timing set and unknown flag
  function automatic lcd_decode_t id_to_timing(input logic [2:0] m,
                                               input logic [15:0] default_id);
    lcd_decode_t d;
    d.unknown = 1'b0;
    case (m)
      M_4342:  d.id = ID_4342;
      M_7084:  d.id = ID_7084;
      M_7016:  d.id = ID_7016;
      M_4384:  d.id = ID_4384;
      M_1018:  d.id = ID_1018;
      default: begin
        d.id      = default_id;
        d.unknown = 1'b1;
      end
    endcase
    d.tim = timing_for_id(d.id);
    return d;
  endfunction

endpackage

// File: rtl/lcd_sync_gen.sv
// Raster counters and registered HS/VS/DE plus the one-cycle-early pixel request.
module lcd_sync_gen
  import lcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  lcd_timing_t tim,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic        data_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos
);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic [10:0] h_start;
  logic [10:0] h_end;
  logic [10:0] v_start;
  logic [10:0] v_end;
  logic        req_nxt;

  // Front porches are implied by the totals and are not needed here
  logic unused_porch;
  assign unused_porch = ^{tim.hf, tim.vf};

  // Next raster position and whether that position lies in the active window
  always_comb begin
    h_nxt   = h_cnt + 11'd1;
    v_nxt   = v_cnt;
    h_start = tim.hs + tim.hb;
    h_end   = h_start + tim.hd;
    v_start = tim.vs + tim.vb;
    v_end   = v_start + tim.vd;
    if (h_cnt == tim.ht - 11'd1) begin
      h_nxt = 11'd0;
      v_nxt = (v_cnt == tim.vt - 11'd1) ? 11'd0 : v_cnt + 11'd1;
    end
    req_nxt = run && (h_nxt >= h_start) && (h_nxt < h_end) &&
              (v_nxt >= v_start) && (v_nxt < v_end);
  end

  // Counters and sync outputs; data_req tracks the current counter so that
  // lcd_de, a plain delay of data_req, lands one cycle after the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt      <= 11'd0;
      v_cnt      <= 11'd0;
      lcd_hs     <= 1'b1;
      lcd_vs     <= 1'b1;
      lcd_de     <= 1'b0;
      data_req   <= 1'b0;
      pixel_xpos <= 11'd0;
      pixel_ypos <= 11'd0;
    end else if (!run) begin
      h_cnt      <= 11'd0;
      v_cnt      <= 11'd0;
      lcd_hs     <= 1'b1;
      lcd_vs     <= 1'b1;
      lcd_de     <= 1'b0;
      data_req   <= 1'b0;
      pixel_xpos <= 11'd0;
      pixel_ypos <= 11'd0;
    end else begin
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      lcd_hs     <= !(h_cnt < tim.hs);
      lcd_vs     <= !(v_cnt < tim.vs);
      data_req   <= req_nxt;
      lcd_de     <= data_req;
      pixel_xpos <= req_nxt ? (h_nxt - h_start + 11'd1) : 11'd0;
      pixel_ypos <= req_nxt ? (v_nxt - v_start) : 11'd0;
    end
  end

endmodule

// File: rtl/lcd_id_timing.sv
// Panel ID strap read-back after reset, then raster timing for the decoded panel.
// Renderer interface: data_req/pixel_xpos/pixel_ypos form a request with no
// back-pressure; the renderer must present pixel_data exactly one cycle after
// each data_req, and that cycle is the one where lcd_de is high.
module lcd_id_timing
  import lcd_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [15:0] DEFAULT_ID    = 16'h4342
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] lcd_rgb_in,
  input  logic [15:0] pixel_data,
  output logic [15:0] lcd_rgb_out,
  output logic        lcd_rgb_oe,
  output logic        lcd_de,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_bl,
  output logic        data_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic [15:0] lcd_id,
  output logic        id_unknown
);

  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

  lcd_state_t  state;
  logic [SW-1:0] settle_cnt;
  lcd_timing_t tim;
  lcd_decode_t dec;
  logic        run;

  assign dec = id_to_timing({lcd_rgb_in[4], lcd_rgb_in[10], lcd_rgb_in[15]}, DEFAULT_ID);
  assign run = (state == ST_RUN);

  // Bring-up sequence: let the released bus settle, latch the strap once, then run
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
      tim        <= '0;
      lcd_id     <= 16'h0;
      id_unknown <= 1'b0;
      h_disp     <= 11'd0;
      v_disp     <= 11'd0;
      lcd_rgb_oe <= 1'b0;
      lcd_bl     <= 1'b0;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state <= ST_SAMPLE;
          else                                        settle_cnt <= settle_cnt + 1'b1;
        end
        ST_SAMPLE: begin
          tim        <= dec.tim;
          lcd_id     <= dec.id;
          id_unknown <= dec.unknown;
          h_disp     <= dec.tim.hd;
          v_disp     <= dec.tim.vd;
          lcd_rgb_oe <= 1'b1;
          lcd_bl     <= 1'b1;
          state      <= ST_RUN;
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_SETTLE;
        end
      endcase
    end
  end

  lcd_sync_gen u_sync (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .run        (run),
    .tim        (tim),
    .lcd_hs     (lcd_hs),
    .lcd_vs     (lcd_vs),
    .lcd_de     (lcd_de),
    .data_req   (data_req),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos)
  );

  // Pixel arrives the cycle lcd_de is high; blank elsewhere
  assign lcd_rgb_out = lcd_de ? pixel_data : 16'h0;

endmodule

// File: tb/tb_lcd_id_timing.sv
// Directed bench for lcd_id_timing: strap decode, sync shapes and a pixel scoreboard.
module tb_lcd_id_timing;

  localparam int SETTLE = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] lcd_rgb_in = 16'h0;
  logic [15:0] pixel_data = 16'h0;
  logic [15:0] lcd_rgb_out;
  logic        lcd_rgb_oe;
  logic        lcd_de;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_bl;
  logic        data_req;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [10:0] h_disp;
  logic [10:0] v_disp;
  logic [15:0] lcd_id;
  logic        id_unknown;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int de_bad = 0;
  int since_fall = 0;
  logic hs_q = 1'b1;
  logic de_q = 1'b0;
  logic req_q = 1'b0;
  logic req_qq = 1'b0;
  logic [15:0] exp_q[$];

  // Clock and reset block
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  lcd_id_timing #(.SETTLE_CYCLES(SETTLE), .DEFAULT_ID(16'h4342)) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .lcd_rgb_in  (lcd_rgb_in),
    .pixel_data  (pixel_data),
    .lcd_rgb_out (lcd_rgb_out),
    .lcd_rgb_oe  (lcd_rgb_oe),
    .lcd_de      (lcd_de),
    .lcd_hs      (lcd_hs),
    .lcd_vs      (lcd_vs),
    .lcd_bl      (lcd_bl),
    .data_req    (data_req),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .h_disp      (h_disp),
    .v_disp      (v_disp),
    .lcd_id      (lcd_id),
    .id_unknown  (id_unknown)
  );

  // Renderer model: registered pixel for the requested coordinate
  always @(posedge clk) pixel_data <= {5'b0, pixel_xpos ^ pixel_ypos};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next sampling point and update the running monitors
  task automatic step();
    req_qq = req_q;
    hs_q   = lcd_hs;
    de_q   = lcd_de;
    req_q  = data_req;
    @(negedge clk);
    if (lcd_de && (!lcd_hs || !lcd_vs)) de_bad++;
    if (hs_q && !lcd_hs) since_fall = 0;
    else                 since_fall++;
  endtask

  // Reset with a strap on the bus, check reset values, then time the ID phase
  task automatic reset_and_start(input logic [15:0] strap);
    int n;
    rst_n = 1'b0;
    lcd_rgb_in = strap;
    repeat (3) step();
    chk("rst_oe", lcd_rgb_oe, 0);
    chk("rst_rgb_out", lcd_rgb_out, 0);
    chk("rst_de", lcd_de, 0);
    chk("rst_hs", lcd_hs, 1);
    chk("rst_vs", lcd_vs, 1);
    chk("rst_bl", lcd_bl, 0);
    chk("rst_req", data_req, 0);
    chk("rst_xpos", pixel_xpos, 0);
    chk("rst_ypos", pixel_ypos, 0);
    chk("rst_h_disp", h_disp, 0);
    chk("rst_v_disp", v_disp, 0);
    chk("rst_lcd_id", lcd_id, 0);
    chk("rst_id_unknown", id_unknown, 0);
    rst_n = 1'b1;
    n = 0;
    while (!lcd_rgb_oe && n < 100) begin
      n++;
      step();
    end
    chk("settle_len", n, SETTLE + 1);
    chk("run_bl", lcd_bl, 1);
    chk("run_first_hs", lcd_hs, 1);
  endtask

  task automatic measure_hs(input int exp_low, input int exp_period);
    int n;
    int low;
    int per;
    bit found;
    found = 0;
    for (n = 0; n < 5000 && !found; n++) begin
      step();
      if (hs_q && !lcd_hs) found = 1;
    end
    chk("hs_fall_seen", found, 1);
    low = 0;
    while (!lcd_hs && low < 5000) begin
      low++;
      step();
    end
    per = low;
    while (lcd_hs && per < 10000) begin
      per++;
      step();
    end
    chk("hs_low_len", low, exp_low);
    chk("hs_period", per, exp_period);
  endtask

  initial begin
    int n;
    int run_len;
    int ex_x;
    int ey;
    int lines_done;
    int de_cnt;
    int last_x;
    int guard;

    #2;
    // 800x480 panel from strap M=100
    reset_and_start(16'h0010);
    chk("id_4384", lcd_id, 16'h4384);
    chk("h_disp_4384", h_disp, 800);
    chk("v_disp_4384", v_disp, 480);
    chk("unknown_4384", id_unknown, 0);
    measure_hs(128, 1056);

    // 480x272 panel from strap M=000
    reset_and_start(16'h0000);
    chk("id_4342", lcd_id, 16'h4342);
    chk("h_disp_4342", h_disp, 480);
    chk("v_disp_4342", v_disp, 272);
    n = 0;
    while (lcd_vs && n < 10) begin
      n++;
      step();
    end
    n = 0;
    while (!lcd_vs && n < 20000) begin
      n++;
      step();
    end
    chk("vs_low_len", n, 10 * 525);
    measure_hs(41, 525);
    n = 0;
    while (!lcd_de && n < 2000) begin
      n++;
      step();
    end
    chk("de_rise_seen", lcd_de, 1);
    chk("de_after_hs_fall", since_fall, 43);
    run_len = 0;
    while (lcd_de && run_len < 2000) begin
      run_len++;
      step();
    end
    chk("de_line_len", run_len, 480);
    chk("req_leads_de_fall", {req_qq, req_q}, 2'b10);

    // Unrecognised strap M=111 falls back to the default panel
    reset_and_start(16'h8410);
    chk("id_unknown_flag", id_unknown, 1);
    chk("id_default", lcd_id, 16'h4342);
    chk("h_disp_default", h_disp, 480);
    chk("v_disp_default", v_disp, 272);
    measure_hs(41, 525);

    // 1024x600 panel, scoreboard over two full lines of pixels
    reset_and_start(16'h0400);
    chk("id_7016", lcd_id, 16'h7016);
    chk("h_disp_7016", h_disp, 1024);
    chk("v_disp_7016", v_disp, 600);
    n = 0;
    while (!data_req && n < 40000) begin
      n++;
      step();
    end
    chk("first_req_pos", n, 23 * 1344 + 160);
    chk("first_req_x", pixel_xpos, 1);
    chk("first_req_y", pixel_ypos, 0);
    exp_q.delete();
    ey = -1;
    ex_x = 1;
    lines_done = 0;
    de_cnt = 0;
    last_x = 0;
    guard = 0;
    while (lines_done < 2 && guard < 4000) begin
      if (data_req) begin
        if (!req_q) begin
          ey++;
          ex_x = 1;
        end
        chk("req_xpos", pixel_xpos, ex_x);
        chk("req_ypos", pixel_ypos, ey);
        exp_q.push_back(16'(ex_x ^ ey));
        last_x = int'(pixel_xpos);
        ex_x++;
      end
      if (lcd_de) begin
        de_cnt++;
        if (exp_q.size() == 0) chk("sb_underflow", 0, 1);
        else                   chk("rgb_out", lcd_rgb_out, exp_q.pop_front());
      end
      if (de_q && !lcd_de) begin
        lines_done++;
        chk("req_leads_de_7016", {req_qq, req_q}, 2'b10);
      end
      step();
      guard++;
    end
    chk("sb_lines", lines_done, 2);
    chk("sb_de_count", de_cnt, 2 * 1024);
    chk("sb_queue_empty", exp_q.size(), 0);
    chk("last_req_x", last_x, 1024);

    // Reset in the middle of an active line
    n = 0;
    while (!lcd_de && n < 2000) begin
      n++;
      step();
    end
    repeat (100) step();
    chk("pre_rst_de", lcd_de, 1);
    rst_n = 1'b0;
    #1;
    chk("async_de", lcd_de, 0);
    chk("async_bl", lcd_bl, 0);
    chk("async_oe", lcd_rgb_oe, 0);
    chk("async_req", data_req, 0);
    chk("async_hs", lcd_hs, 1);
    chk("async_vs", lcd_vs, 1);
    chk("async_rgb_out", lcd_rgb_out, 0);
    @(negedge clk);
    reset_and_start(16'h8000);
    chk("reread_id_7084", lcd_id, 16'h7084);
    chk("reread_h_disp", h_disp, 800);
    chk("reread_v_disp", v_disp, 480);
    chk("reread_unknown", id_unknown, 0);

    chk("de_during_sync", de_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
